// File: rtl/burst_addr_gen_pkg.sv
// Shared widths, state encoding and mode constants for the burst address generator.
package burst_addr_gen_pkg;

  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_LEN_W    = 8;
  localparam int unsigned DEF_ADDR_INC = 1;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_BURST  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/burst_beat_counter.sv
// Beat index counter: clears to zero, steps on inc, flags when the terminal value is reached.
module burst_beat_counter
  import burst_addr_gen_pkg::*;
#(
  parameter int unsigned LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic [LEN_W-1:0] term_i,
  output logic [LEN_W-1:0] count_o,
  output logic             is_last_c
);

  logic [LEN_W-1:0] count_q;
  logic [LEN_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count_o   = count_q;
  assign is_last_c = (count_q == term_i);

endmodule

// File: rtl/burst_addr_gen.sv
// Burst address generator: latches a start address and length, then emits one
// address per accepted beat and pulses stop_signal after the final beat.
module burst_addr_gen
  import burst_addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned LEN_W    = DEF_LEN_W,
  parameter int unsigned ADDR_INC = DEF_ADDR_INC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode_sel,
  input  logic              load,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              abort,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              addr_last,
  output logic [LEN_W-1:0]  beat_cnt,
  output logic              busy,
  output logic              stop_signal
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic              valid_q;
  logic              last_q;
  logic              busy_q;
  logic              stop_q;

  logic [LEN_W-1:0]  cnt;
  logic              cnt_is_last;
  logic              cnt_clear;
  logic              cnt_inc;
  logic              accept;
  logic              in_burst;

  // valid_q is only ever set in ACTIVE; en gates it so a frozen burst never handshakes
  assign addr_valid = valid_q & en;
  assign accept     = addr_valid & addr_ready;
  assign in_burst   = (state_q == S_ACTIVE) || (state_q == S_DONE);
  assign cnt_clear  = rst || (in_burst && abort) || (state_q == S_DONE);
  assign cnt_inc    = (state_q == S_ACTIVE) && accept && !abort && !cnt_is_last;

  burst_beat_counter #(
    .LEN_W(LEN_W)
  ) u_beat_counter (
    .clk       (clk),
    .clear_i   (cnt_clear),
    .inc_i     (cnt_inc),
    .term_i    (len_q),
    .count_o   (cnt),
    .is_last_c (cnt_is_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          stop_q <= 1'b0;
          if (load && en && !abort) begin
            state_q <= S_ACTIVE;
            addr_q  <= start_addr;
            len_q   <= (mode_sel == MODE_BURST) ? burst_len : '0;
            valid_q <= 1'b1;
            last_q  <= (mode_sel == MODE_BURST) ? (burst_len == '0) : 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_ACTIVE: begin
          if (abort) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (accept) begin
            if (cnt_is_last) begin
              state_q <= S_DONE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              stop_q  <= 1'b1;
            end else begin
              addr_q <= addr_q + ADDR_W'(ADDR_INC);
              last_q <= ((cnt + LEN_W'(1)) == len_q);
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          stop_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
          stop_q  <= 1'b0;
        end
      endcase
    end
  end

  assign addr_out    = addr_q;
  assign addr_last   = last_q;
  assign beat_cnt    = cnt;
  assign busy        = busy_q;
  assign stop_signal = stop_q;

endmodule
